// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared constants for the SAP control sequencer and datapath
package sap_pkg;

  // T-states per instruction and the width of the step register
  localparam int NUM_T = 6;
  localparam int T_W   = 3;

  localparam logic [T_W-1:0] T0 = 3'd0;
  localparam logic [T_W-1:0] T1 = 3'd1;
  localparam logic [T_W-1:0] T2 = 3'd2;
  localparam logic [T_W-1:0] T3 = 3'd3;
  localparam logic [T_W-1:0] T4 = 3'd4;
  localparam logic [T_W-1:0] T5 = 3'd5;

  // Opcodes live in IR[7:4]; anything not listed here executes as NOP
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Control-word bit positions, shared with the datapath top
  localparam int CW_PC_INC     = 0;
  localparam int CW_PC_JUMP    = 1;
  localparam int CW_PC_CLR     = 2;
  localparam int CW_PC_OE      = 3;
  localparam int CW_MAR_LOAD   = 4;
  localparam int CW_RAM_OE     = 5;
  localparam int CW_RAM_WE     = 6;
  localparam int CW_IR_LOAD    = 7;
  localparam int CW_IR_OE      = 8;
  localparam int CW_A_LOAD     = 9;
  localparam int CW_A_OE       = 10;
  localparam int CW_B_LOAD     = 11;
  localparam int CW_ALU_OE     = 12;
  localparam int CW_ALU_SUB    = 13;
  localparam int CW_FLAGS_LOAD = 14;
  localparam int CW_OUT_LOAD   = 15;
  localparam int CW_W          = 16;

  typedef logic [CW_W-1:0] ctrl_word_t;

  // Fetch is identical for every opcode, so it is decoded here once
  function automatic ctrl_word_t fetch_word(input logic [T_W-1:0] t);
    ctrl_word_t w;
    w = '0;
    case (t)
      T0: begin
        w[CW_PC_OE]    = 1'b1;
        w[CW_MAR_LOAD] = 1'b1;
      end
      T1: w[CW_PC_INC] = 1'b1;
      T2: begin
        w[CW_RAM_OE]  = 1'b1;
        w[CW_IR_LOAD] = 1'b1;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sap_step_counter.sv
// rtl/sap_step_counter.sv - T-state register with clear, hold and wrap
module sap_step_counter
  import sap_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic           clr,
  input  logic           hold,
  output logic [T_W-1:0] t_state
);

  // Advance one step per clock, wrapping after the last T-state; hold freezes it
  always_ff @(posedge clk) begin
    if (rstn) begin
      t_state <= T0;
    end else if (clr) begin
      t_state <= T0;
    end else if (hold) begin
      t_state <= t_state;
    end else if (t_state >= T_W'(NUM_T - 1)) begin
      t_state <= T0;
    end else begin
      t_state <= t_state + T_W'(1);
    end
  end

endmodule

// File: rtl/sap_control_sequencer.sv
// rtl/sap_control_sequencer.sv - microcode sequencer for the 8-bit bus CPU
module sap_control_sequencer
  import sap_pkg::*;
(
  input  logic           clk,
  input  logic           rstn,
  input  logic           clr,
  input  logic [3:0]     opcode,
  input  logic           flag_c,
  input  logic           flag_z,
  output logic           pc_inc,
  output logic           pc_jump,
  output logic           pc_clr,
  output logic           pc_oe,
  output logic           mar_load,
  output logic           ram_oe,
  output logic           ram_we,
  output logic           ir_load,
  output logic           ir_oe,
  output logic           a_load,
  output logic           a_oe,
  output logic           b_load,
  output logic           alu_oe,
  output logic           alu_sub,
  output logic           flags_load,
  output logic           out_load,
  output logic           halted,
  output logic [T_W-1:0] t_state
);

  ctrl_word_t cw;

  sap_step_counter u_step_counter (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (clr),
    .hold    (halted),
    .t_state (t_state)
  );

  // HLT latches here at the end of T3; only reset or a soft clear releases it
  always_ff @(posedge clk) begin
    if (rstn) begin
      halted <= 1'b0;
    end else if (clr) begin
      halted <= 1'b0;
    end else if (!halted && (t_state == T3) && (opcode == OP_HLT)) begin
      halted <= 1'b1;
    end
  end

  // Decode the control word from step, opcode and flags; reset, clear and halt override
  always_comb begin
    cw = '0;
    if (rstn) begin
      cw = '0;
    end else if (clr) begin
      cw[CW_PC_CLR] = 1'b1;
    end else if (!halted) begin
      case (t_state)
        T0, T1, T2: cw = fetch_word(t_state);
        T3: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cw[CW_IR_OE]    = 1'b1;
              cw[CW_MAR_LOAD] = 1'b1;
            end
            OP_LDI: begin
              cw[CW_IR_OE]  = 1'b1;
              cw[CW_A_LOAD] = 1'b1;
            end
            OP_JMP: begin
              cw[CW_IR_OE]   = 1'b1;
              cw[CW_PC_JUMP] = 1'b1;
            end
            OP_JC: begin
              cw[CW_IR_OE]   = flag_c;
              cw[CW_PC_JUMP] = flag_c;
            end
            OP_JZ: begin
              cw[CW_IR_OE]   = flag_z;
              cw[CW_PC_JUMP] = flag_z;
            end
            OP_OUT: begin
              cw[CW_A_OE]     = 1'b1;
              cw[CW_OUT_LOAD] = 1'b1;
            end
            default: cw = '0;
          endcase
        end
        T4: begin
          case (opcode)
            OP_LDA: begin
              cw[CW_RAM_OE] = 1'b1;
              cw[CW_A_LOAD] = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              cw[CW_RAM_OE] = 1'b1;
              cw[CW_B_LOAD] = 1'b1;
            end
            OP_STA: begin
              cw[CW_A_OE]   = 1'b1;
              cw[CW_RAM_WE] = 1'b1;
            end
            default: cw = '0;
          endcase
        end
        T5: begin
          case (opcode)
            OP_ADD, OP_SUB: begin
              cw[CW_ALU_OE]     = 1'b1;
              cw[CW_A_LOAD]     = 1'b1;
              cw[CW_FLAGS_LOAD] = 1'b1;
              cw[CW_ALU_SUB]    = (opcode == OP_SUB);
            end
            default: cw = '0;
          endcase
        end
        default: cw = '0;
      endcase
    end
  end

  assign pc_inc     = cw[CW_PC_INC];
  assign pc_jump    = cw[CW_PC_JUMP];
  assign pc_clr     = cw[CW_PC_CLR];
  assign pc_oe      = cw[CW_PC_OE];
  assign mar_load   = cw[CW_MAR_LOAD];
  assign ram_oe     = cw[CW_RAM_OE];
  assign ram_we     = cw[CW_RAM_WE];
  assign ir_load    = cw[CW_IR_LOAD];
  assign ir_oe      = cw[CW_IR_OE];
  assign a_load     = cw[CW_A_LOAD];
  assign a_oe       = cw[CW_A_OE];
  assign b_load     = cw[CW_B_LOAD];
  assign alu_oe     = cw[CW_ALU_OE];
  assign alu_sub    = cw[CW_ALU_SUB];
  assign flags_load = cw[CW_FLAGS_LOAD];
  assign out_load   = cw[CW_OUT_LOAD];

  // Bus has a single driver per cycle, the PC never sees inc+jump, and pc_clr follows clr
  always_ff @(posedge clk) begin
    if (!rstn) begin
      assert ($onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}));
      assert (!(pc_inc && pc_jump));
      assert (!pc_clr || clr);
    end
  end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// tb/tb_sap_control_sequencer.sv - directed and random checks of the SAP control sequencer
module tb_sap_control_sequencer;

  localparam logic [15:0] PC_INC     = 16'h0001;
  localparam logic [15:0] PC_JUMP    = 16'h0002;
  localparam logic [15:0] PC_CLR     = 16'h0004;
  localparam logic [15:0] PC_OE      = 16'h0008;
  localparam logic [15:0] MAR_LOAD   = 16'h0010;
  localparam logic [15:0] RAM_OE     = 16'h0020;
  localparam logic [15:0] RAM_WE     = 16'h0040;
  localparam logic [15:0] IR_LOAD    = 16'h0080;
  localparam logic [15:0] IR_OE      = 16'h0100;
  localparam logic [15:0] A_LOAD     = 16'h0200;
  localparam logic [15:0] A_OE       = 16'h0400;
  localparam logic [15:0] B_LOAD     = 16'h0800;
  localparam logic [15:0] ALU_OE     = 16'h1000;
  localparam logic [15:0] ALU_SUB    = 16'h2000;
  localparam logic [15:0] FLAGS_LOAD = 16'h4000;
  localparam logic [15:0] OUT_LOAD   = 16'h8000;

  logic       clk = 1'b0;
  logic       rstn, clr, flag_c, flag_z;
  logic [3:0] opcode;
  logic       pc_inc, pc_jump, pc_clr, pc_oe, mar_load, ram_oe, ram_we, ir_load, ir_oe;
  logic       a_load, a_oe, b_load, alu_oe, alu_sub, flags_load, out_load, halted;
  logic [2:0] t_state;
  logic [15:0] obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sap_control_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .opcode     (opcode),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .pc_inc     (pc_inc),
    .pc_jump    (pc_jump),
    .pc_clr     (pc_clr),
    .pc_oe      (pc_oe),
    .mar_load   (mar_load),
    .ram_oe     (ram_oe),
    .ram_we     (ram_we),
    .ir_load    (ir_load),
    .ir_oe      (ir_oe),
    .a_load     (a_load),
    .a_oe       (a_oe),
    .b_load     (b_load),
    .alu_oe     (alu_oe),
    .alu_sub    (alu_sub),
    .flags_load (flags_load),
    .out_load   (out_load),
    .halted     (halted),
    .t_state    (t_state)
  );

  assign obs = {out_load, flags_load, alu_sub, alu_oe, b_load, a_oe, a_load, ir_oe,
                ir_load, ram_we, ram_oe, mar_load, pc_oe, pc_clr, pc_jump, pc_inc};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full instruction from T0 and returns at T0 of the next one
  task automatic run_instr(input logic [3:0] op, input logic fc, input logic fz,
                           input logic [15:0] e3, input logic [15:0] e4, input logic [15:0] e5);
    logic [15:0] exp_cw [6];
    exp_cw[0] = PC_OE | MAR_LOAD;
    exp_cw[1] = PC_INC;
    exp_cw[2] = RAM_OE | IR_LOAD;
    exp_cw[3] = e3;
    exp_cw[4] = e4;
    exp_cw[5] = e5;
    opcode = op;
    flag_c = fc;
    flag_z = fz;
    #1;
    for (int k = 0; k < 6; k++) begin
      check_eq($sformatf("op%0h_t%0d_state", op, k), 32'(t_state), 32'(k));
      check_eq($sformatf("op%0h_t%0d_cw", op, k), 32'(obs), 32'(exp_cw[k]));
      tick();
      #1;
    end
    check_eq($sformatf("op%0h_wrap", op), 32'(t_state), 32'd0);
  endtask

  int exp_t;
  int exp_h;

  initial begin
    rstn = 1'b1;
    clr = 1'b0;
    opcode = 4'h0;
    flag_c = 1'b0;
    flag_z = 1'b0;

    for (int i = 0; i < 2; i++) begin
      tick();
      #1;
      check_eq($sformatf("reset_cw_%0d", i), 32'(obs), 32'd0);
    end
    check_eq("reset_state", 32'(t_state), 32'd0);
    check_eq("reset_halted", 32'(halted), 32'd0);
    rstn = 1'b0;
    #1;
    check_eq("post_reset_cw", 32'(obs), 32'(PC_OE | MAR_LOAD));

    run_instr(4'h2, 0, 0, IR_OE | MAR_LOAD, RAM_OE | B_LOAD, ALU_OE | A_LOAD | FLAGS_LOAD);
    run_instr(4'h3, 0, 0, IR_OE | MAR_LOAD, RAM_OE | B_LOAD, ALU_OE | A_LOAD | FLAGS_LOAD | ALU_SUB);
    run_instr(4'h1, 0, 0, IR_OE | MAR_LOAD, RAM_OE | A_LOAD, 16'h0);
    run_instr(4'h4, 0, 0, IR_OE | MAR_LOAD, A_OE | RAM_WE, 16'h0);
    run_instr(4'h5, 0, 0, IR_OE | A_LOAD, 16'h0, 16'h0);
    run_instr(4'h6, 0, 0, IR_OE | PC_JUMP, 16'h0, 16'h0);
    run_instr(4'h7, 0, 1, 16'h0, 16'h0, 16'h0);
    run_instr(4'h7, 1, 0, IR_OE | PC_JUMP, 16'h0, 16'h0);
    run_instr(4'h8, 1, 0, 16'h0, 16'h0, 16'h0);
    run_instr(4'h8, 0, 1, IR_OE | PC_JUMP, 16'h0, 16'h0);
    run_instr(4'hE, 0, 0, A_OE | OUT_LOAD, 16'h0, 16'h0);
    run_instr(4'h0, 1, 1, 16'h0, 16'h0, 16'h0);
    run_instr(4'hA, 1, 1, 16'h0, 16'h0, 16'h0);

    // HLT: walk to T3, then expect freeze at T4 with all controls low
    opcode = 4'hF;
    for (int k = 0; k < 3; k++) tick();
    #1;
    check_eq("hlt_t3_state", 32'(t_state), 32'd3);
    check_eq("hlt_t3_cw", 32'(obs), 32'd0);
    check_eq("hlt_t3_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      check_eq($sformatf("halt_state_%0d", i), 32'(t_state), 32'd4);
      check_eq($sformatf("halt_flag_%0d", i), 32'(halted), 32'd1);
      check_eq($sformatf("halt_cw_%0d", i), 32'(obs), 32'd0);
    end
    clr = 1'b1;
    #1;
    check_eq("halt_clr_cw", 32'(obs), 32'(PC_CLR));
    tick();
    clr = 1'b0;
    opcode = 4'h0;
    #1;
    check_eq("halt_clr_state", 32'(t_state), 32'd0);
    check_eq("halt_clr_halted", 32'(halted), 32'd0);
    check_eq("halt_clr_cw_t0", 32'(obs), 32'(PC_OE | MAR_LOAD));

    // Soft clear during STA T4 must suppress the write
    opcode = 4'h4;
    for (int k = 0; k < 4; k++) tick();
    #1;
    check_eq("sta_t4_state", 32'(t_state), 32'd4);
    clr = 1'b1;
    #1;
    check_eq("sta_clr_cw", 32'(obs), 32'(PC_CLR));
    tick();
    clr = 1'b0;
    #1;
    check_eq("sta_clr_state", 32'(t_state), 32'd0);

    // Random opcodes, flags and occasional clears against a small step model
    exp_t = 0;
    exp_h = 0;
    for (int i = 0; i < 3000; i++) begin
      opcode = 4'($urandom_range(0, 15));
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 31) == 0);
      #2;
      check_eq("rnd_state", 32'(t_state), 32'(exp_t));
      check_eq("rnd_halted", 32'(halted), 32'(exp_h));
      check_eq("rnd_bus_excl", 32'($countones({pc_oe, ram_oe, ir_oe, a_oe, alu_oe}) <= 1), 32'd1);
      check_eq("rnd_inc_jump", 32'(pc_inc & pc_jump), 32'd0);
      check_eq("rnd_pc_clr", 32'(pc_clr), 32'(clr));
      if (clr) begin
        exp_t = 0;
        exp_h = 0;
      end else if (exp_h == 0) begin
        if (exp_t == 3 && opcode == 4'hF) begin
          exp_t = 4;
          exp_h = 1;
        end else begin
          exp_t = (exp_t == 5) ? 0 : exp_t + 1;
        end
      end
      tick();
    end

    // Reset has priority over clear
    rstn = 1'b1;
    clr = 1'b1;
    #1;
    check_eq("rst_over_clr_cw", 32'(obs), 32'd0);
    tick();
    rstn = 1'b0;
    clr = 1'b0;
    #1;
    check_eq("rst_over_clr_state", 32'(t_state), 32'd0);
    check_eq("rst_over_clr_halted", 32'(halted), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
